// File: rtl/demux_1xn_reg.sv
// Registered 1-to-N demux with per-channel one-entry holding registers, broadcast and bad-select flag.
// Latency: 1 cycle from accept edge to out_valid/out_data.
// Backpressure: in_ready follows the target channel(s) being free; a draining channel can reload in the same cycle.
module demux_1xn_reg #(
    parameter int WIDTH = 8,
    parameter int N     = 8,
    parameter int SEL_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 bcast,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic [N-1:0]         out_valid,
    output logic [N*WIDTH-1:0]   out_data,
    input  logic [N-1:0]         out_ready,
    output logic                 sel_err,
    input  logic                 clr_err
);

    generate
        if ((2 ** SEL_W) < N) begin : g_sel_w_check
            $error("demux_1xn_reg: SEL_W too narrow for N channels");
        end
    endgenerate

    localparam logic [SEL_W:0] N_L = (SEL_W + 1)'(N);

    logic [N-1:0] free;
    logic [N-1:0] load;
    logic         in_range;
    logic         free_sel;
    logic         accept;
    logic         bad_accept;

    // A channel can take a word if it is empty or is being emptied this cycle.
    assign free     = ~out_valid | out_ready;
    assign in_range = ({1'b0, sel} < N_L);

    always_comb begin
        free_sel = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) begin
                free_sel = free[i];
            end
        end
    end

    // Out-of-range selects are always accepted so the producer never stalls on them.
    always_comb begin
        if (!rst_n || !en) begin
            in_ready = 1'b0;
        end else if (bcast) begin
            in_ready = &free;
        end else if (!in_range) begin
            in_ready = 1'b1;
        end else begin
            in_ready = free_sel;
        end
    end

    assign accept     = in_valid & in_ready;
    assign bad_accept = accept & ~bcast & ~in_range;

    always_comb begin
        load = '0;
        for (int i = 0; i < N; i++) begin
            load[i] = accept & (bcast | (sel == SEL_W'(i)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_data  <= '0;
            sel_err   <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (load[i]) begin
                    out_valid[i]                 <= 1'b1;
                    out_data[i*WIDTH +: WIDTH]   <= in_data;
                end else if (out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
            if (bad_accept) begin
                sel_err <= 1'b1;
            end else if (clr_err) begin
                sel_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_demux_1xn_reg.sv
// Bench for demux_1xn_reg: an 8-channel instance against a cycle model and scoreboard queue,
// plus a 6-channel instance for the out-of-range select flag.
module tb_demux_1xn_reg;

    logic clk;
    logic rst_n;

    // 8-channel instance
    logic        en_a, bcast_a, vld_a, rdy_a, err_a, clr_a;
    logic [2:0]  sel_a;
    logic [7:0]  din_a, ordy_a, ov_a;
    logic [63:0] od_a;

    // 6-channel instance
    logic        en_b, bcast_b, vld_b, rdy_b, err_b, clr_b;
    logic [2:0]  sel_b;
    logic [7:0]  din_b;
    logic [5:0]  ordy_b, ov_b;
    logic [47:0] od_b;

    demux_1xn_reg #(.WIDTH(8), .N(8), .SEL_W(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .bcast(bcast_a), .sel(sel_a),
        .in_valid(vld_a), .in_data(din_a), .in_ready(rdy_a),
        .out_valid(ov_a), .out_data(od_a), .out_ready(ordy_a),
        .sel_err(err_a), .clr_err(clr_a)
    );

    demux_1xn_reg #(.WIDTH(8), .N(6), .SEL_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .bcast(bcast_b), .sel(sel_b),
        .in_valid(vld_b), .in_data(din_b), .in_ready(rdy_b),
        .out_valid(ov_b), .out_data(od_b), .out_ready(ordy_b),
        .sel_err(err_b), .clr_err(clr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  v;
        logic [63:0] d;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  mv;
    logic [63:0] md;
    int          n_vec;
    int          n_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle on the 8-channel instance: inputs are already driven.
    task automatic step_a();
        logic [7:0] fr;
        logic       er;
        logic       acc;
        exp_t       e;
        #1;
        fr = ~mv | ordy_a;
        if (!en_a)        er = 1'b0;
        else if (bcast_a) er = (fr == 8'hFF);
        else              er = fr[sel_a];
        chk("in_ready", {63'd0, rdy_a}, {63'd0, er});
        acc = vld_a && er;
        for (int i = 0; i < 8; i++) begin
            if (acc && (bcast_a || (sel_a == i))) begin
                mv[i]         = 1'b1;
                md[i*8 +: 8]  = din_a;
            end else if (ordy_a[i]) begin
                mv[i] = 1'b0;
            end
        end
        e.v = mv;
        e.d = md;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = sbq.pop_front();
            chk("out_valid", {56'd0, ov_a}, {56'd0, e.v});
            chk("out_data", od_a, e.d);
            chk("sel_err_a", {63'd0, err_a}, 64'd0);
        end
    endtask

    task automatic drive_a(input logic v, input logic b, input logic [2:0] s,
                           input logic [7:0] d, input logic [7:0] r);
        vld_a   = v;
        bcast_a = b;
        sel_a   = s;
        din_a   = d;
        ordy_a  = r;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        mv = '0;
        md = '0;
        rst_n = 1'b0;
        en_a = 1'b1; clr_a = 1'b0;
        drive_a(1'b0, 1'b0, 3'd0, 8'h00, 8'hFF);
        en_b = 1'b1; bcast_b = 1'b0; vld_b = 1'b0; sel_b = 3'd0; din_b = 8'h00;
        ordy_b = 6'h3F; clr_b = 1'b0;

        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, rdy_a}, 64'd0);
        chk("rst_out_valid", {56'd0, ov_a}, 64'd0);
        chk("rst_out_data", od_a, 64'd0);
        chk("rst_sel_err", {63'd0, err_b}, 64'd0);
        rst_n = 1'b1;
        step_a();
        step_a();

        // Sweep all channels, full throughput
        for (int s = 0; s < 8; s++) begin
            drive_a(1'b1, 1'b0, 3'(s), 8'(8'h10 + s), 8'hFF);
            step_a();
            chk("sweep_onehot", {56'd0, ov_a}, 64'd1 << s);
            chk("sweep_data", {56'd0, od_a[s*8 +: 8]}, 64'(8'h10 + s));
        end

        // Backpressure on channel 3, no bubble on release
        drive_a(1'b1, 1'b0, 3'd3, 8'hAA, 8'hF7); step_a();
        drive_a(1'b1, 1'b0, 3'd3, 8'hBB, 8'hF7); step_a();
        chk("bp_hold", {56'd0, od_a[31:24]}, 64'hAA);
        drive_a(1'b1, 1'b0, 3'd4, 8'h44, 8'hF7); step_a();
        drive_a(1'b1, 1'b0, 3'd3, 8'hBB, 8'hFF); step_a();
        chk("bp_reload", {56'd0, od_a[31:24]}, 64'hBB);
        drive_a(1'b0, 1'b0, 3'd0, 8'h00, 8'hFF); step_a();

        // Broadcast blocked by full channel 6, then atomic broadcast
        drive_a(1'b1, 1'b0, 3'd6, 8'h66, 8'hBF); step_a();
        drive_a(1'b1, 1'b1, 3'd0, 8'h5C, 8'hBF); step_a();
        drive_a(1'b1, 1'b1, 3'd2, 8'h5C, 8'hFF); step_a();
        chk("bcast_valid", {56'd0, ov_a}, 64'hFF);
        chk("bcast_data", od_a, 64'h5C5C5C5C5C5C5C5C);
        drive_a(1'b0, 1'b0, 3'd0, 8'h00, 8'hFF); step_a();

        // Enable low blocks accepts
        en_a = 1'b0;
        drive_a(1'b1, 1'b0, 3'd1, 8'h77, 8'hFF); step_a();
        en_a = 1'b1;

        // Random traffic
        for (int k = 0; k < 60; k++) begin
            en_a = ($urandom_range(0, 7) != 0);
            drive_a($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                    3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            step_a();
        end
        en_a = 1'b1;
        drive_a(1'b0, 1'b0, 3'd0, 8'h00, 8'hFF); step_a();

        // Out-of-range select on the 6-channel instance
        vld_b = 1'b1; sel_b = 3'd7; din_b = 8'h99;
        #1 chk("oor_ready", {63'd0, rdy_b}, 64'd1);
        @(posedge clk); #1;
        chk("oor_valid", {58'd0, ov_b}, 64'd0);
        chk("oor_err_set", {63'd0, err_b}, 64'd1);
        vld_b = 1'b0;
        @(posedge clk); #1;
        chk("oor_err_sticky", {63'd0, err_b}, 64'd1);
        vld_b = 1'b1; sel_b = 3'd6; clr_b = 1'b1;
        @(posedge clk); #1;
        chk("oor_set_wins", {63'd0, err_b}, 64'd1);
        chk("oor_valid2", {58'd0, ov_b}, 64'd0);
        vld_b = 1'b0;
        @(posedge clk); #1;
        chk("oor_clear", {63'd0, err_b}, 64'd0);
        clr_b = 1'b0; vld_b = 1'b1; sel_b = 3'd5; din_b = 8'h42; ordy_b = 6'h00;
        @(posedge clk); #1;
        chk("b_ch5_valid", {58'd0, ov_b}, 64'h20);
        chk("b_ch5_data", {56'd0, od_b[47:40]}, 64'h42);
        sel_b = 3'd7;
        @(posedge clk); #1;
        chk("b_err_again", {63'd0, err_b}, 64'd1);
        vld_b = 1'b0;

        // Reset mid-operation, asserted between clock edges
        drive_a(1'b1, 1'b0, 3'd0, 8'hA0, 8'h00); step_a();
        drive_a(1'b1, 1'b0, 3'd2, 8'hA2, 8'h00); step_a();
        drive_a(1'b1, 1'b0, 3'd5, 8'hA5, 8'h00); step_a();
        chk("pre_rst_valid", {56'd0, ov_a}, 64'h25);
        en_a = 1'b0;
        drive_a(1'b1, 1'b0, 3'd1, 8'hA1, 8'h00); step_a();
        en_a = 1'b1;
        drive_a(1'b0, 1'b0, 3'd0, 8'h00, 8'h00); step_a();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {56'd0, ov_a}, 64'd0);
        chk("async_rst_data", od_a, 64'd0);
        chk("async_rst_ready", {63'd0, rdy_a}, 64'd0);
        chk("async_rst_err", {63'd0, err_b}, 64'd0);
        chk("async_rst_valid_b", {58'd0, ov_b}, 64'd0);
        mv = '0;
        md = '0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive_a(1'b1, 1'b0, 3'd7, 8'hE7, 8'hFF); step_a();
        drive_a(1'b0, 1'b0, 3'd0, 8'h00, 8'hFF); step_a();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case something stalls the stimulus thread.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
